operand_issue: RTL

//  Register-file reader and scoreboard client between decode and execute. Holds one decoded

---
 rtl/operand_issue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/operand_issue.sv
// Operand collection stage between decode and execute: holds one instruction, gathers rs1/rs2
// from the regfile or the writeback bypass, then issues and reserves rd in the scoreboard.
module operand_issue #(
  parameter int PAYLOAD_W = 32,
  parameter int STALL_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_flush,
  input  logic                 i_dec_valid,
  output logic                 o_dec_ready,
  input  logic [4:0]           i_dec_rs1,
  input  logic [4:0]           i_dec_rs2,
  input  logic                 i_dec_use_rs1,
  input  logic                 i_dec_use_rs2,
  input  logic [4:0]           i_dec_rd,
  input  logic                 i_dec_wb,
  input  logic [PAYLOAD_W-1:0] i_dec_payload,
  output logic [4:0]           o_rf_rs1,
  output logic [4:0]           o_rf_rs2,
  input  logic                 i_rf_rs1_valid,
  input  logic                 i_rf_rs2_valid,
  input  logic [31:0]          i_rf_rs1_data,
  input  logic [31:0]          i_rf_rs2_data,
  output logic [4:0]           o_rf_rd,
  output logic                 o_rf_reserve,
  input  logic                 i_wb0_en,
  input  logic [4:0]           i_wb0_reg,
  input  logic [31:0]          i_wb0_data,
  input  logic                 i_wb1_en,
  input  logic [4:0]           i_wb1_reg,
  input  logic [31:0]          i_wb1_data,
  output logic                 o_ex_valid,
  input  logic                 i_ex_ready,
  output logic [31:0]          o_ex_op1,
  output logic [31:0]          o_ex_op2,
  output logic [4:0]           o_ex_rd,
  output logic                 o_ex_wb,
  output logic [PAYLOAD_W-1:0] o_ex_payload,
  output logic [STALL_W-1:0]   o_stall_cycles
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_WAIT = 2'd1, S_ISSUE = 2'd2} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0][4:0]       r_rs;
  logic [1:0]            r_use;
  logic [1:0]            r_cap;
  logic [1:0][31:0]      r_op;
  logic [4:0]            r_rd;
  logic                  r_wb;
  logic [PAYLOAD_W-1:0]  r_payload;
  logic [STALL_W-1:0]    r_stall;

  logic [1:0]            w_rf_valid;
  logic [1:0][31:0]      w_rf_data;
  logic [1:0]            w_ok;
  logic [1:0][31:0]      w_val;
  logic                  w_done, w_wbhit, w_fire, w_accept;

  assign w_rf_valid = {i_rf_rs2_valid, i_rf_rs1_valid};
  assign w_rf_data  = {i_rf_rs2_data, i_rf_rs1_data};

  // Per-operand source select; wb0 ahead of wb1 since port 0 wins a same-register collision.
  always_comb begin
    w_ok  = '0;
    w_val = '0;
    for (int i = 0; i < 2; i++) begin
      if (!r_use[i] || r_rs[i] == 5'd0) begin
        w_ok[i] = 1'b1;
      end else if (i_wb0_en && i_wb0_reg == r_rs[i]) begin
        w_ok[i]  = 1'b1;
        w_val[i] = i_wb0_data;
      end else if (i_wb1_en && i_wb1_reg == r_rs[i]) begin
        w_ok[i]  = 1'b1;
        w_val[i] = i_wb1_data;
      end else if (w_rf_valid[i]) begin
        w_ok[i]  = 1'b1;
        w_val[i] = w_rf_data[i];
      end
    end
  end

  assign w_done = &(r_cap | w_ok);

  // A writeback to rd in the issue cycle would clobber the fresh reservation, so hold off.
  assign w_wbhit = r_wb && (r_rd != 5'd0) &&
                   ((i_wb0_en && i_wb0_reg == r_rd) || (i_wb1_en && i_wb1_reg == r_rd));
  assign w_fire  = (r_state == S_ISSUE) && i_ex_ready && !i_flush && !w_wbhit;

  assign o_dec_ready = !i_flush && ((r_state == S_EMPTY) || w_fire);
  assign w_accept    = i_dec_valid && o_dec_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done)   w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_fire)   w_state_nxt = w_accept ? S_WAIT : S_EMPTY;
      default:               w_state_nxt = S_EMPTY;
    endcase
    if (i_flush) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_EMPTY;
      r_rs      <= '0;
      r_use     <= '0;
      r_cap     <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_wb      <= 1'b0;
      r_payload <= '0;
      r_stall   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_WAIT && r_stall != {STALL_W{1'b1}})
        r_stall <= r_stall + STALL_W'(1);
      if (w_accept) begin
        r_rs      <= {i_dec_rs2, i_dec_rs1};
        r_use     <= {i_dec_use_rs2, i_dec_use_rs1};
        r_rd      <= i_dec_rd;
        r_wb      <= i_dec_wb;
        r_payload <= i_dec_payload;
        r_cap     <= '0;
      end else if (r_state == S_WAIT) begin
        for (int i = 0; i < 2; i++) begin
          if (!r_cap[i] && w_ok[i]) begin
            r_cap[i] <= 1'b1;
            r_op[i]  <= w_val[i];
          end
        end
      end
    end
  end

  assign o_rf_rs1       = r_rs[0];
  assign o_rf_rs2       = r_rs[1];
  assign o_rf_rd        = r_rd;
  assign o_rf_reserve   = w_fire && r_wb && (r_rd != 5'd0);
  assign o_ex_valid     = (r_state == S_ISSUE);
  assign o_ex_op1       = r_op[0];
  assign o_ex_op2       = r_op[1];
  assign o_ex_rd        = r_rd;
  assign o_ex_wb        = r_wb;
  assign o_ex_payload   = r_payload;
  assign o_stall_cycles = r_stall;

endmodule
